mmcm_lock_rstgen: RTL and testbench



---
 rtl/mmcm_lock_rstgen_if.sv | 37 +++
 rtl/mmcm_lock_rstgen.sv | 153 +++++++++++++++
 tb/tb_mmcm_lock_rstgen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_lock_rstgen_if.sv
// Status/control bundle between the MMCM reset sequencer and its surroundings.
interface mmcm_lock_rstgen_if #(
    parameter int unsigned EVT_WIDTH = 8
);
    logic                 locked_async;
    logic                 force_rst;
    logic                 mmcm_rst;
    logic                 rst_out_n;
    logic                 ready;
    logic [1:0]           state;
    logic [EVT_WIDTH-1:0] lock_loss_cnt;
    logic [EVT_WIDTH-1:0] timeout_cnt;

    // Controller / environment side: drives MMCM lock and reset requests.
    modport master (
        output locked_async,
        output force_rst,
        input  mmcm_rst,
        input  rst_out_n,
        input  ready,
        input  state,
        input  lock_loss_cnt,
        input  timeout_cnt
    );

    // Sequencer side.
    modport slave (
        input  locked_async,
        input  force_rst,
        output mmcm_rst,
        output rst_out_n,
        output ready,
        output state,
        output lock_loss_cnt,
        output timeout_cnt
    );
endinterface

// File: rtl/mmcm_lock_rstgen.sv
// MMCM reset sequencer: pulses MMCM RST, waits for a stable lock, then
// releases the downstream reset; re-sequences on lock loss, timeout or request.
module mmcm_lock_rstgen #(
    parameter int unsigned RST_CYCLES    = 100,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned EVT_WIDTH     = 8
) (
    input  logic              clk,
    input  logic              aresetn,
    mmcm_lock_rstgen_if.slave bus
);
    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        WAIT   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] RST_LOAD    = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD   = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [EVT_WIDTH-1:0] EVT_MAX     = {EVT_WIDTH{1'b1}};

    logic                 sync1_q;
    logic                 locked_s_q;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 loss_evt, tmo_evt;
    logic                 mmcm_rst_q, mmcm_rst_d;
    logic                 rst_out_n_q, rst_out_n_d;
    logic                 ready_q, ready_d;
    logic [EVT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;
    logic [EVT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

    // Two-flop synchronizer for the asynchronous LOCKED signal.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= bus.locked_async;
            locked_s_q <= sync1_q;
        end
    end

    // State, shared down-counter, event counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q     <= HOLD;
            cnt_q       <= RST_LOAD;
            mmcm_rst_q  <= 1'b1;
            rst_out_n_q <= 1'b0;
            ready_q     <= 1'b0;
            loss_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mmcm_rst_q  <= mmcm_rst_d;
            rst_out_n_q <= rst_out_n_d;
            ready_q     <= ready_d;
            loss_cnt_q  <= loss_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Next state and counter; force_rst outranks lock, lock outranks expiry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_evt = 1'b0;
        tmo_evt  = 1'b0;
        case (state_q)
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end else if (!bus.force_rst) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (bus.force_rst) begin
                    state_d = HOLD;
                    cnt_d   = RST_LOAD;
                end else if (locked_s_q) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = RST_LOAD;
                    tmo_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            SETTLE: begin
                if (bus.force_rst) begin
                    state_d = HOLD;
                    cnt_d   = RST_LOAD;
                end else if (!locked_s_q) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            RUN: begin
                if (bus.force_rst) begin
                    state_d = HOLD;
                    cnt_d   = RST_LOAD;
                end else if (!locked_s_q) begin
                    state_d  = HOLD;
                    cnt_d    = RST_LOAD;
                    loss_evt = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = RST_LOAD;
            end
        endcase
    end

    // Output values for the next state, plus saturating event counts.
    always_comb begin
        mmcm_rst_d  = 1'b0;
        rst_out_n_d = 1'b0;
        ready_d     = 1'b0;
        loss_cnt_d  = loss_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        mmcm_rst_d  = (state_d == HOLD);
        rst_out_n_d = (state_d == RUN);
        ready_d     = (state_d == RUN);
        if (loss_evt && (loss_cnt_q != EVT_MAX)) begin
            loss_cnt_d = loss_cnt_q + EVT_WIDTH'(1);
        end
        if (tmo_evt && (tmo_cnt_q != EVT_MAX)) begin
            tmo_cnt_d = tmo_cnt_q + EVT_WIDTH'(1);
        end
    end

    assign bus.mmcm_rst      = mmcm_rst_q;
    assign bus.rst_out_n     = rst_out_n_q;
    assign bus.ready         = ready_q;
    assign bus.state         = state_q;
    assign bus.lock_loss_cnt = loss_cnt_q;
    assign bus.timeout_cnt   = tmo_cnt_q;
endmodule

// File: tb/tb_mmcm_lock_rstgen.sv
// Bench for mmcm_lock_rstgen: elapsed-time reference model feeds an
// expectation queue; a negedge monitor pops and compares every cycle.
module tb_mmcm_lock_rstgen;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int CNT_WIDTH     = 16;
    localparam int EVT_WIDTH     = 4;
    localparam int EVT_MAX       = 15;

    localparam int P_HOLD   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_RUN    = 3;

    typedef struct packed {
        logic [1:0] state;
        logic       mmcm_rst;
        logic       rst_out_n;
        logic       ready;
        logic [3:0] loss;
        logic [3:0] tmo;
    } obs_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;

    mmcm_lock_rstgen_if #(.EVT_WIDTH(EVT_WIDTH)) bus ();

    mmcm_lock_rstgen #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_WIDTH    (CNT_WIDTH),
        .EVT_WIDTH    (EVT_WIDTH)
    ) dut (
        .clk    (clk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: phase plus the edge at which it was entered.
    int cyc     = 0;
    int m_phase = P_HOLD;
    int m_t0    = 0;
    int m_loss  = 0;
    int m_tmo   = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    task automatic enter(input int p);
        m_phase = p;
        m_t0    = cyc;
    endtask

    always @(posedge clk) begin : model
        bit   lk;
        obs_t e;
        cyc = cyc + 1;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.locked_async;
        if (!aresetn) begin
            m_s1   = 1'b0;
            m_s2   = 1'b0;
            m_loss = 0;
            m_tmo  = 0;
            enter(P_HOLD);
        end else begin
            case (m_phase)
                P_HOLD: begin
                    if (!bus.force_rst && (cyc - m_t0) >= RST_CYCLES) enter(P_WAIT);
                end
                P_WAIT: begin
                    if (bus.force_rst) enter(P_HOLD);
                    else if (lk) enter(P_SETTLE);
                    else if ((cyc - m_t0) >= LOCK_TIMEOUT) begin
                        enter(P_HOLD);
                        if (m_tmo < EVT_MAX) m_tmo = m_tmo + 1;
                    end
                end
                P_SETTLE: begin
                    if (bus.force_rst) enter(P_HOLD);
                    else if (!lk) enter(P_WAIT);
                    else if ((cyc - m_t0) >= STABLE_CYCLES) enter(P_RUN);
                end
                P_RUN: begin
                    if (bus.force_rst) enter(P_HOLD);
                    else if (!lk) begin
                        enter(P_HOLD);
                        if (m_loss < EVT_MAX) m_loss = m_loss + 1;
                    end
                end
                default: enter(P_HOLD);
            endcase
        end
        e.state     = 2'(m_phase);
        e.mmcm_rst  = (m_phase == P_HOLD);
        e.rst_out_n = (m_phase == P_RUN);
        e.ready     = (m_phase == P_RUN);
        e.loss      = 4'(m_loss);
        e.tmo       = 4'(m_tmo);
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin : monitor
        obs_t got;
        obs_t e;
        if (exp_q.size() > 0) begin
            e             = exp_q.pop_front();
            got.state     = bus.state;
            got.mmcm_rst  = bus.mmcm_rst;
            got.rst_out_n = bus.rst_out_n;
            got.ready     = bus.ready;
            got.loss      = bus.lock_loss_cnt;
            got.tmo       = bus.timeout_cnt;
            n_checks = n_checks + 1;
            if (got !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL outputs cyc=%0d: got state=%0d mmcm_rst=%b rst_out_n=%b ready=%b loss=%0d tmo=%0d, expected state=%0d mmcm_rst=%b rst_out_n=%b ready=%b loss=%0d tmo=%0d",
                         cyc, got.state, got.mmcm_rst, got.rst_out_n, got.ready, got.loss, got.tmo,
                         e.state, e.mmcm_rst, e.rst_out_n, e.ready, e.loss, e.tmo);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int p, input int limit, input string what);
        int k;
        k = 0;
        while (m_phase != p && k < limit) begin
            tick(1);
            k = k + 1;
        end
        if (m_phase != p) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL wait_%s: phase %0d after %0d cycles, expected %0d", what, m_phase, limit, p);
        end
    endtask

    initial begin
        bus.locked_async = 1'b0;
        bus.force_rst    = 1'b0;
        aresetn          = 1'b0;
        tick(3);
        aresetn = 1'b1;

        // Repeated lock timeouts, enough to saturate timeout_cnt.
        tick(17 * (RST_CYCLES + LOCK_TIMEOUT) + 3);

        // Normal lock at a random point inside WAIT.
        wait_phase(P_WAIT, 60, "wait1");
        tick(int'($urandom_range(0, LOCK_TIMEOUT - 4)));
        bus.locked_async = 1'b1;
        wait_phase(P_RUN, 100, "run1");
        tick(5);

        // Short lock loss in RUN, then recovery.
        bus.locked_async = 1'b0;
        tick(int'($urandom_range(1, 3)));
        bus.locked_async = 1'b1;
        wait_phase(P_HOLD, 10, "hold_loss");
        wait_phase(P_RUN, 200, "run2");
        tick(5);

        // Forced reset from RUN for 10 cycles.
        bus.force_rst = 1'b1;
        tick(10);
        bus.force_rst = 1'b0;
        wait_phase(P_RUN, 200, "run3");
        tick(5);

        // Glitch during SETTLE, then a clean lock.
        bus.locked_async = 1'b0;
        wait_phase(P_HOLD, 10, "hold_g");
        wait_phase(P_WAIT, 20, "wait_g");
        bus.locked_async = 1'b1;
        tick(5);
        bus.locked_async = 1'b0;
        tick(1);
        bus.locked_async = 1'b1;
        wait_phase(P_RUN, 100, "run4");
        tick(5);

        // Reset pulse while in SETTLE.
        bus.locked_async = 1'b0;
        wait_phase(P_HOLD, 10, "hold_r");
        wait_phase(P_WAIT, 20, "wait_r");
        bus.locked_async = 1'b1;
        wait_phase(P_SETTLE, 10, "settle_r");
        tick(2);
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        tick(40);

        // Random lock activity, force requests and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.locked_async = ~bus.locked_async;
            if (bus.force_rst) begin
                if ($urandom_range(0, 4) == 0) bus.force_rst = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                bus.force_rst = 1'b1;
            end
            aresetn = ($urandom_range(0, 399) != 0);
            tick(1);
        end

        bus.locked_async = 1'b1;
        bus.force_rst    = 1'b0;
        aresetn          = 1'b1;
        tick(40);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
